// File: rtl/sensor_debounce.sv
// sensor_debounce: four independent counter-based debounce filters feeding sensor_s.
// Define SENSOR_DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer ahead of the filters.
module sensor_debounce #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw_sensors,
    output logic [3:0] sensors,
    output logic       change,
    output logic       busy
);

    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    logic [3:0] s_in;
    logic [3:0] sensors_next;
    logic       busy_next;
    logic [7:0] cnt      [4];
    logic [7:0] cnt_next [4];

`ifdef SENSOR_DEBOUNCE_SYNC_EN
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    // Two-stage synchronizer; raw lines are asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 4'b0000;
            sync_q2 <= 4'b0000;
        end else begin
            sync_q1 <= raw_sensors;
            sync_q2 <= sync_q1;
        end
    end

    assign s_in = sync_q2;
`else
    assign s_in = raw_sensors;
`endif

    // A channel's counter only runs while its input disagrees with its output;
    // the >= guard keeps the counter from ever passing LAST.
    always_comb begin
        sensors_next = sensors;
        busy_next    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cnt_next[i] = 8'd0;
            if (s_in[i] != sensors[i]) begin
                if (cnt[i] >= LAST) begin
                    sensors_next[i] = s_in[i];
                end else begin
                    cnt_next[i] = cnt[i] + 8'd1;
                end
            end
            busy_next = busy_next | (cnt_next[i] != 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sensors <= 4'b0000;
            change  <= 1'b0;
            busy    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 8'd0;
            end
        end else begin
            sensors <= sensors_next;
            change  <= |(sensors_next ^ sensors);
            busy    <= busy_next;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: doc/sensor_debounce.md
SENSOR_DEBOUNCE -- requirements
Module: sensor_debounce

Interface
REQ-001 SHALL have parameter: STABLE_CYCLES, default 4, consecutive sampled cycles a raw input must differ from its output before the output updates (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: raw_sensors  input  4  unfiltered sensor lines, asynchronous to clk.
REQ-005 SHALL have port: sensors  output  4  debounced sensor vector, registered; drives the downstream sensor_s sensors input directly.
REQ-006 SHALL have port: change  output  1  registered one-cycle pulse; high when any sensors bit updated at the preceding edge.
REQ-007 SHALL have port: busy  output  1  registered; high while any channel counter is non-zero.

Function
REQ-008 SHALL process four independent channels i = 0..3, each with its own 8-bit counter cnt[i] and a sampled input s_in[i].
REQ-009 s_in[i] SHALL be raw_sensors[i] sampled as defined under Configuration.
REQ-010 At each edge where s_in[i] == sensors[i], cnt[i] SHALL clear to 0 and sensors[i] SHALL hold.
REQ-011 At each edge where s_in[i] != sensors[i] and cnt[i] < STABLE_CYCLES-1, cnt[i] SHALL increment by 1 and sensors[i] SHALL hold.
REQ-012 At each edge where s_in[i] != sensors[i] and cnt[i] == STABLE_CYCLES-1, sensors[i] SHALL load s_in[i] and cnt[i] SHALL clear to 0.
REQ-013 Latency: a mismatch first sampled at edge k and held SHALL update sensors[i] at edge k+STABLE_CYCLES-1; with STABLE_CYCLES=1, sensors[i] updates at the first mismatching edge.
REQ-014 A mismatch that disappears before the update edge (glitch) SHALL leave sensors[i] unchanged and SHALL clear cnt[i]; a new mismatch restarts counting from 0.
REQ-015 Counters SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-016 change SHALL be high for exactly the cycle following any edge at which one or more sensors bits changed value; simultaneous updates on several channels SHALL produce a single one-cycle pulse.
REQ-017 Updates at consecutive edges on different channels SHALL produce change high for consecutive cycles, one cycle per updating edge.
REQ-018 busy SHALL be the registered OR of (cnt[i] != 0) over all channels, i.e. it reflects the counter values after each edge.
REQ-019 Channels SHALL be fully independent; activity on one channel SHALL never alter another channel's counter.

Reset
REQ-020 While rst is high at an edge: sensors SHALL be 4'b0000, change 0, busy 0, all cnt[i] 0, and all synchronizer flops 0.
REQ-021 Reset asserted mid-count SHALL discard partial counts; after release, a full STABLE_CYCLES of mismatch SHALL be required again.
REQ-022 The first edge after rst deasserts SHALL evaluate channels normally against sensors = 4'b0000.

Configuration
REQ-023 Macro SENSOR_DEBOUNCE_SYNC_EN: when defined, s_in SHALL come from a 2-flop synchronizer on raw_sensors, adding 2 cycles to the REQ-013 latency.
REQ-024 Without SENSOR_DEBOUNCE_SYNC_EN, s_in SHALL be raw_sensors taken directly at the clock edge, with no added latency.
REQ-025 Port list, reset values and counting rules SHALL be identical in both builds.

Verification (STABLE_CYCLES=4, macro undefined unless stated)
REQ-026 Hold rst for 2 edges with raw=4'b1111 -> sensors=4'b0000, change=0, busy=0 during and immediately after reset.
REQ-027 raw 0000->0001 held -> busy high after first edge, sensors=0001 at 4th edge, change high exactly one cycle, busy low afterward.
REQ-028 raw bit1 high for 3 cycles, then back to 0 -> sensors stays 0000, change never asserts, busy returns to 0.
REQ-029 raw 0000->1110 on all channels at once, held -> all three bits update at the same edge, a single change pulse; the sensor_s error output goes 1.
REQ-030 Mismatch for 2 edges, then rst for 1 edge, then raw held -> sensors updates exactly 4 edges after reset release, not earlier.
REQ-031 SENSOR_DEBOUNCE_SYNC_EN defined, raw 0000->1000 held -> sensors=1000 at the 6th edge after the raw change.
